fg_sram_fetch: RTL and testbench

//  Foreground frame-store access unit between the controlled pipeline and the external synchronous SRAM.

---
 rtl/fg_sram_fetch.sv | 187 ++++++++++++++++++
 tb/tb_fg_sram_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fg_sram_fetch.sv
// rtl/fg_sram_fetch.sv - foreground frame-store SRAM access unit
// Fixed-latency pixel reads own the SRAM port; capture/upload writes queue and drain on idle slots.
module fg_sram_fetch #(
    parameter int PIXEL_SIZE        = 16,
    parameter int PRECISION         = 11,
    parameter int RESOLUTION_X      = 800,
    parameter int RESOLUTION_Y      = 600,
    parameter int ADDR_WIDTH        = 19,
    parameter int SRAM_READ_LATENCY = 2,
    parameter int FETCH_DELAY       = 5,
    parameter int WFIFO_DEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PRECISION:0]      fg_pixel_request_x,
    input  logic [PRECISION:0]      fg_pixel_request_y,
    input  logic                    fg_pixel_request_active,
    output logic [PIXEL_SIZE-1:0]   fg_pixel_in,
    output logic                    fg_pixel_ready,
    input  logic [PRECISION-1:0]    vid_wr_x,
    input  logic [PRECISION-1:0]    vid_wr_y,
    input  logic [PIXEL_SIZE-1:0]   vid_wr_pixel,
    input  logic                    vid_wr_valid,
    input  logic                    ctrl_fg_freeze,
    input  logic [PRECISION-1:0]    ctrl_image_pixel_x,
    input  logic [PRECISION-1:0]    ctrl_image_pixel_y,
    input  logic [PIXEL_SIZE-1:0]   ctrl_image_pixel,
    input  logic                    ctrl_image_pixel_ready,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [PIXEL_SIZE-1:0]   sram_wdata,
    output logic                    sram_we,
    output logic                    sram_re,
    input  logic [PIXEL_SIZE-1:0]   sram_rdata,
    output logic                    wfifo_full,
    output logic [15:0]             wr_drop_count
);

    localparam int PTR_W    = $clog2(WFIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int VLEN     = FETCH_DELAY - 1;
    localparam int DATA_TAP = FETCH_DELAY - SRAM_READ_LATENCY - 3;
    localparam logic [PRECISION-1:0]  RES_X_P = PRECISION'(RESOLUTION_X);
    localparam logic [PRECISION-1:0]  RES_Y_P = PRECISION'(RESOLUTION_Y);
    localparam logic [ADDR_WIDTH-1:0] RES_X_A = ADDR_WIDTH'(RESOLUTION_X);
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(WFIFO_DEPTH);

    function automatic logic in_frame(input logic [PRECISION-1:0] x, input logic [PRECISION-1:0] y);
        return (x < RES_X_P) && (y < RES_Y_P);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] xy_addr(input logic [PRECISION-1:0] x,
                                                      input logic [PRECISION-1:0] y);
        return ADDR_WIDTH'(y) * RES_X_A + ADDR_WIDTH'(x);
    endfunction

    logic [VLEN-1:0]        r_vpipe;
    logic [ADDR_WIDTH-1:0]  r_fifo_addr [WFIFO_DEPTH];
    logic [PIXEL_SIZE-1:0]  r_fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_rd_hit;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;
    logic                   w_spi_ok;
    logic                   w_vid_ok;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_room;
    logic                   w_enq;
    logic [ADDR_WIDTH-1:0]  w_push_addr;
    logic [PIXEL_SIZE-1:0]  w_push_data;
    logic [1:0]             w_drops;
    logic [16:0]            w_drop_sum;
    logic [CNT_W-1:0]       w_count_next;
    logic [PIXEL_SIZE-1:0]  w_tap;

    // Negative request coords are rejected by their sign bit before the unsigned range test.
    assign w_rd_hit  = fg_pixel_request_active
                     & ~fg_pixel_request_x[PRECISION] & ~fg_pixel_request_y[PRECISION]
                     & in_frame(fg_pixel_request_x[PRECISION-1:0], fg_pixel_request_y[PRECISION-1:0]);
    assign w_rd_addr = xy_addr(fg_pixel_request_x[PRECISION-1:0], fg_pixel_request_y[PRECISION-1:0]);

    assign w_spi_ok    = ctrl_image_pixel_ready & in_frame(ctrl_image_pixel_x, ctrl_image_pixel_y);
    assign w_vid_ok    = vid_wr_valid & ~ctrl_fg_freeze & in_frame(vid_wr_x, vid_wr_y);
    assign w_push      = w_spi_ok | w_vid_ok;
    assign w_push_addr = w_spi_ok ? xy_addr(ctrl_image_pixel_x, ctrl_image_pixel_y)
                                  : xy_addr(vid_wr_x, vid_wr_y);
    assign w_push_data = w_spi_ok ? ctrl_image_pixel : vid_wr_pixel;
    assign w_pop       = ~w_rd_hit & (r_count != '0);
    assign w_room      = ~wfifo_full | w_pop;
    assign w_enq       = w_push & w_room;
    assign w_drops     = {1'b0, w_spi_ok & w_vid_ok} + {1'b0, w_push & ~w_room};
    assign w_drop_sum  = {1'b0, wr_drop_count} + {15'd0, w_drops};

    always_comb begin
        w_count_next = r_count;
        if (w_enq && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_enq && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_addr[r_wptr] <= w_push_addr;
            r_fifo_data[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            wfifo_full    <= 1'b0;
            wr_drop_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count       <= w_count_next;
            wfifo_full    <= (w_count_next == DEPTH_C);
            wr_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    // SRAM port: a read request always takes the slot; a write drains only when no read is present.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
            sram_re    <= 1'b0;
        end else begin
            sram_re <= w_rd_hit;
            sram_we <= w_pop;
            if (w_rd_hit) begin
                sram_addr <= w_rd_addr;
            end else if (w_pop) begin
                sram_addr  <= r_fifo_addr[r_rptr];
                sram_wdata <= r_fifo_data[r_rptr];
            end
        end
    end

    generate
        if (DATA_TAP < 0) begin : g_direct
            assign w_tap = sram_rdata;
        end else begin : g_dpipe
            logic [PIXEL_SIZE-1:0] r_dpipe [DATA_TAP+1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i <= DATA_TAP; i++) begin
                        r_dpipe[i] <= '0;
                    end
                end else begin
                    r_dpipe[0] <= sram_rdata;
                    for (int i = 1; i <= DATA_TAP; i++) begin
                        r_dpipe[i] <= r_dpipe[i-1];
                    end
                end
            end
            assign w_tap = r_dpipe[DATA_TAP];
        end
    endgenerate

    // r_vpipe[k] marks an in-range request issued k+1 cycles ago; the top bit lines up with w_tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vpipe        <= '0;
            fg_pixel_ready <= 1'b0;
            fg_pixel_in    <= '0;
        end else begin
            r_vpipe        <= {r_vpipe[VLEN-2:0], w_rd_hit};
            fg_pixel_ready <= r_vpipe[VLEN-1];
            if (r_vpipe[VLEN-1]) begin
                fg_pixel_in <= w_tap;
            end
        end
    end

endmodule

// File: tb/tb_fg_sram_fetch.sv
// tb/tb_fg_sram_fetch.sv - directed self-checking bench for fg_sram_fetch
module tb_fg_sram_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] req_x, req_y;
    logic        req_act;
    logic [15:0] fg_pixel_in;
    logic        fg_pixel_ready;
    logic [10:0] vid_x, vid_y;
    logic [15:0] vid_pix;
    logic        vid_valid;
    logic        freeze;
    logic [10:0] spi_x, spi_y;
    logic [15:0] spi_pix;
    logic        spi_rdy;
    logic [18:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_we, sram_re;
    logic [15:0] sram_rdata = 16'h0;
    logic        wfifo_full;
    logic [15:0] wr_drop_count;

    logic [15:0] mem [0:524287];
    logic [15:0] r_s1 = 16'h0;

    int checks = 0;
    int errors = 0;

    fg_sram_fetch dut (
        .clk                    (clk),
        .rst                    (rst),
        .fg_pixel_request_x     (req_x),
        .fg_pixel_request_y     (req_y),
        .fg_pixel_request_active(req_act),
        .fg_pixel_in            (fg_pixel_in),
        .fg_pixel_ready         (fg_pixel_ready),
        .vid_wr_x               (vid_x),
        .vid_wr_y               (vid_y),
        .vid_wr_pixel           (vid_pix),
        .vid_wr_valid           (vid_valid),
        .ctrl_fg_freeze         (freeze),
        .ctrl_image_pixel_x     (spi_x),
        .ctrl_image_pixel_y     (spi_y),
        .ctrl_image_pixel       (spi_pix),
        .ctrl_image_pixel_ready (spi_rdy),
        .sram_addr              (sram_addr),
        .sram_wdata             (sram_wdata),
        .sram_we                (sram_we),
        .sram_re                (sram_re),
        .sram_rdata             (sram_rdata),
        .wfifo_full             (wfifo_full),
        .wr_drop_count          (wr_drop_count)
    );

    always #5 clk = ~clk;

    // Two-cycle read latency SRAM model: re seen at one edge, data out after the next.
    always @(posedge clk) begin
        r_s1       <= sram_re ? mem[sram_addr] : 16'h0;
        sram_rdata <= r_s1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic bad;

    initial begin
        rst = 1'b1; req_x = '0; req_y = '0; req_act = 1'b0;
        vid_x = '0; vid_y = '0; vid_pix = '0; vid_valid = 1'b0; freeze = 1'b0;
        spi_x = '0; spi_y = '0; spi_pix = '0; spi_rdy = 1'b0;
        mem[1610] = 16'hABCD;
        for (int i = 0; i < 8; i++) mem[8000 + i] = 16'hC000 + 16'(i);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 32'(fg_pixel_ready), 32'd0);
        chk("rst_pixel", 32'(fg_pixel_in), 32'd0);
        chk("rst_port", {sram_addr, sram_we, sram_re}, 32'd0);
        chk("rst_full_drop", {wfifo_full, wr_drop_count}, 32'd0);

        // single read (10,2) -> word 1610
        req_x = 12'd10; req_y = 12'd2; req_act = 1'b1;
        tick();
        req_act = 1'b0;
        chk("rd_re", 32'(sram_re), 32'd1);
        chk("rd_addr", 32'(sram_addr), 32'd1610);
        tick(); tick(); tick();
        chk("rd_c4_ready", 32'(fg_pixel_ready), 32'd0);
        tick();
        chk("rd_c5_ready", 32'(fg_pixel_ready), 32'd1);
        chk("rd_c5_data", 32'(fg_pixel_in), 32'hABCD);
        tick();
        chk("rd_c6_ready", 32'(fg_pixel_ready), 32'd0);

        // out-of-range requests x=-1 then x=800
        req_x = 12'hFFF; req_y = 12'd2; req_act = 1'b1;
        tick();
        chk("oor_neg_re", 32'(sram_re), 32'd0);
        req_x = 12'd800;
        tick();
        req_act = 1'b0;
        chk("oor_800_re", 32'(sram_re), 32'd0);
        tick(); tick(); tick();
        chk("oor_neg_ready", 32'(fg_pixel_ready), 32'd0);
        tick();
        chk("oor_800_ready", 32'(fg_pixel_ready), 32'd0);
        chk("oor_hold", 32'(fg_pixel_in), 32'hABCD);

        // SPI and live write collide
        spi_x = 11'd3; spi_y = 11'd0; spi_pix = 16'h1234; spi_rdy = 1'b1;
        vid_x = 11'd5; vid_y = 11'd5; vid_pix = 16'h5555; vid_valid = 1'b1;
        tick();
        spi_rdy = 1'b0; vid_valid = 1'b0;
        tick();
        chk("col_we", 32'(sram_we), 32'd1);
        chk("col_addr", 32'(sram_addr), 32'd3);
        chk("col_wdata", 32'(sram_wdata), 32'h1234);
        chk("col_drop", 32'(wr_drop_count), 32'd1);
        tick();
        chk("col_no_live", 32'(sram_we), 32'd0);

        // 8 back-to-back reads with 6 SPI writes: 4 queue, 2 drop, drain after reads
        bad = 1'b0;
        for (int c = 0; c < 14; c++) begin
            req_act = (c < 8);
            req_x = 12'(c); req_y = 12'd10;
            spi_rdy = (c < 6);
            spi_x = 11'(c); spi_y = 11'd1; spi_pix = 16'h1000 + 16'(c);
            chk($sformatf("b2b_ready_c%0d", c), 32'(fg_pixel_ready), 32'((c >= 5 && c <= 12) ? 1 : 0));
            if (c >= 5 && c <= 12)
                chk($sformatf("b2b_data_c%0d", c), 32'(fg_pixel_in), 32'h0000C000 + 32'(c - 5));
            if (c <= 8 && sram_we) bad = 1'b1;
            if (c == 6) begin
                chk("b2b_full", 32'(wfifo_full), 32'd1);
                chk("b2b_drop", 32'(wr_drop_count), 32'd3);
            end
            if (c >= 9 && c <= 12) begin
                chk($sformatf("drain_we_c%0d", c), 32'(sram_we), 32'd1);
                chk($sformatf("drain_addr_c%0d", c), 32'(sram_addr), 32'd800 + 32'(c - 9));
                chk($sformatf("drain_data_c%0d", c), 32'(sram_wdata), 32'h00001000 + 32'(c - 9));
            end
            tick();
        end
        req_act = 1'b0; spi_rdy = 1'b0;
        chk("b2b_no_we_during_reads", 32'(bad), 32'd0);
        chk("b2b_drained_full", 32'(wfifo_full), 32'd0);
        chk("b2b_drained_we", 32'(sram_we), 32'd0);

        // freeze blocks live capture
        freeze = 1'b1; bad = 1'b0;
        vid_x = 11'd7; vid_y = 11'd7; vid_pix = 16'h7777;
        for (int c = 0; c < 6; c++) begin
            vid_valid = (c < 3);
            if (sram_we) bad = 1'b1;
            tick();
        end
        vid_valid = 1'b0; freeze = 1'b0;
        chk("frz_no_we", 32'(bad), 32'd0);
        chk("frz_drop", 32'(wr_drop_count), 32'd3);
        chk("frz_full", 32'(wfifo_full), 32'd0);

        // reset with reads and writes in flight
        for (int c = 0; c < 3; c++) begin
            req_act = 1'b1; req_x = 12'd20 + 12'(c); req_y = 12'd3;
            spi_rdy = 1'b1; spi_x = 11'(c); spi_y = 11'd4; spi_pix = 16'h4000 + 16'(c);
            tick();
        end
        req_act = 1'b0; spi_rdy = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_drop", 32'(wr_drop_count), 32'd0);
        chk("mrst_full", 32'(wfifo_full), 32'd0);
        chk("mrst_pixel", 32'(fg_pixel_in), 32'd0);
        chk("mrst_addr", 32'(sram_addr), 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (fg_pixel_ready || sram_we || sram_re) bad = 1'b1;
            tick();
        end
        chk("mrst_quiet", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
